// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parameterised UART: TX/RX state encodings,
// oversampling constants and the parity helper.
// Optional feature macro used by the UART files: UART_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Each serial bit lasts this many tick16 pulses.
    localparam int OVERSAMPLE = 16;
    // The start bit is confirmed on this tick, i.e. at the bit centre.
    localparam int SAMPLE_MID = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    // Parity bit for up to 8 data bits (unused upper bits must be zero).
    // odd=0 gives even parity, odd=1 gives odd parity.
    function automatic logic calc_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous first-word fall-through FIFO with occupancy output.
// Ports:
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   i_write, i_data    : push request and data (ignored when full unless a
//                        pop happens in the same cycle)
//   i_read             : pop request (ignored when empty)
//   o_data             : current head entry
//   o_empty, o_full    : status flags
//   o_level            : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_write,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_read,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_read;
    logic             w_do_write;

    assign w_empty    = (r_level == '0);
    assign w_full     = (r_level == FULL_LVL);
    assign w_do_read  = i_read && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_write = i_write && (!w_full || w_do_read);

    // Pointer and level bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_read) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_write, w_do_read})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents need no reset because the level gates visibility.
    always_ff @(posedge clock) begin
        if (w_do_write) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule

// File: rtl/uart_param.sv
// -----------------------------------------------------------------------------
// uart_param
// Parameterised UART with 16x oversampling, TX and RX FIFOs and sticky error
// flags. Optional parity generation/checking is enabled by defining the macro
// UART_PARITY_EN; without it parity_err is tied low.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   baud_div                : clocks per tick16 minus 1 (applied at next wrap)
//   rx / tx                 : serial in (asynchronous) / serial out (idles high)
//   write, data_write       : push into the TX FIFO
//   read, data_read         : pop / head of the RX FIFO (fall-through)
//   data_ready              : RX FIFO not empty
//   tx_full, tx_idle        : TX FIFO full / TX FIFO empty and TX FSM idle
//   rx_level, tx_level      : FIFO occupancies
//   clear_err               : clears sticky flags (a same-cycle event wins)
//   rx_overrun, frame_err,
//   parity_err              : sticky error flags
// -----------------------------------------------------------------------------
module uart_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx,
    output logic                          tx,
    input  logic                          write,
    input  logic [DATA_BITS-1:0]          data_write,
    input  logic                          read,
    output logic [DATA_BITS-1:0]          data_read,
    output logic                          data_ready,
    output logic                          tx_full,
    output logic                          tx_idle,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic [$clog2(FIFO_DEPTH):0]   tx_level,
    input  logic                          clear_err,
    output logic                          rx_overrun,
    output logic                          frame_err,
    output logic                          parity_err
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_LAST  = 4'(SAMPLE_MID - 1);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] r_tick_cnt;
    logic [DIV_W-1:0] r_div;
    logic             w_tick16;

    assign w_tick16 = (r_tick_cnt == r_div);

    // Oversample tick counter; the divisor is re-latched only on wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_div      <= baud_div;
        end else if (w_tick16) begin
            r_tick_cnt <= '0;
            r_div      <= baud_div;
        end else begin
            r_tick_cnt <= r_tick_cnt + DIV_W'(1);
        end
    end

    // ---------------- rx synchroniser ----------------
    logic r_rx_meta;
    logic r_rx_sync;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_empty;
    logic                 w_tx_full;
    logic                 w_tx_pop;
    logic [DATA_BITS-1:0] w_rx_head;
    logic                 w_rx_empty;
    logic                 w_rx_full;
    logic                 w_rx_push;
    logic [DATA_BITS-1:0] r_rx_shift;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_write (write),
        .i_data  (data_write),
        .i_read  (w_tx_pop),
        .o_data  (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full),
        .o_level (tx_level)
    );

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_write (w_rx_push),
        .i_data  (r_rx_shift),
        .i_read  (read),
        .o_data  (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full),
        .o_level (rx_level)
    );

    // ---------------- transmitter ----------------
    tx_state_e            r_tx_state;
    tx_state_e            w_tx_state_nx;
    logic [3:0]           r_tx_ticks;
    logic [3:0]           w_tx_ticks_nx;
    logic [2:0]           r_tx_bits;
    logic [2:0]           w_tx_bits_nx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [DATA_BITS-1:0] w_tx_shift_nx;
    logic                 r_tx;
    logic                 w_tx_nx;
    logic                 w_tx_bit_end;

    assign w_tx_bit_end = w_tick16 && (r_tx_ticks == TICK_LAST);

`ifdef UART_PARITY_EN
    logic       r_tx_par;
    logic [7:0] w_tx_head8;

    // Widen the head word so the 8-bit parity helper sees zeros above DATA_BITS.
    always_comb begin
        w_tx_head8                = 8'd0;
        w_tx_head8[DATA_BITS-1:0] = w_tx_head;
    end

    // Parity of the frame is captured together with its data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_par <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_par <= calc_parity(w_tx_head8, (PARITY_ODD != 0));
        end
    end
`else
    // The odd/even choice has no effect without parity.
    logic w_unused_parity_cfg;
    assign w_unused_parity_cfg = (PARITY_ODD != 0);
`endif

    // TX state, bit timing and the registered serial output.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_ticks <= 4'd0;
            r_tx_bits  <= 3'd0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_ticks <= w_tx_ticks_nx;
            r_tx_bits  <= w_tx_bits_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx       <= w_tx_nx;
        end
    end

    // TX next-state logic; the 4-bit tick counter wraps 15 -> 0 at each bit end.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_ticks_nx = w_tick16 ? (r_tx_ticks + 4'd1) : r_tx_ticks;
        w_tx_bits_nx  = r_tx_bits;
        w_tx_shift_nx = r_tx_shift;
        w_tx_nx       = r_tx;
        w_tx_pop      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_ticks_nx = 4'd0;
                w_tx_bits_nx  = 3'd0;
                w_tx_nx       = 1'b1;
                if (w_tick16 && !w_tx_empty) begin
                    w_tx_pop      = 1'b1;
                    w_tx_shift_nx = w_tx_head;
                    w_tx_state_nx = TX_START;
                    w_tx_nx       = 1'b0;
                end else begin
                    w_tx_state_nx = TX_IDLE;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nx = TX_DATA;
                    w_tx_nx       = r_tx_shift[0];
                end else begin
                    w_tx_state_nx = TX_START;
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    if (r_tx_bits == LAST_DATA) begin
                        w_tx_bits_nx  = 3'd0;
`ifdef UART_PARITY_EN
                        w_tx_state_nx = TX_PARITY;
                        w_tx_nx       = r_tx_par;
`else
                        w_tx_state_nx = TX_STOP;
                        w_tx_nx       = 1'b1;
`endif
                    end else begin
                        w_tx_shift_nx = {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        w_tx_nx       = r_tx_shift[1];
                        w_tx_bits_nx  = r_tx_bits + 3'd1;
                    end
                end else begin
                    w_tx_state_nx = TX_DATA;
                end
            end
            TX_PARITY: begin
`ifdef UART_PARITY_EN
                if (w_tx_bit_end) begin
                    w_tx_state_nx = TX_STOP;
                    w_tx_nx       = 1'b1;
                end else begin
                    w_tx_state_nx = TX_PARITY;
                end
`else
                w_tx_state_nx = TX_IDLE;
                w_tx_nx       = 1'b1;
`endif
            end
            TX_STOP: begin
                w_tx_nx = 1'b1;
                if (w_tx_bit_end) begin
                    if (r_tx_bits == LAST_STOP) begin
                        w_tx_state_nx = TX_IDLE;
                    end else begin
                        w_tx_bits_nx  = r_tx_bits + 3'd1;
                    end
                end else begin
                    w_tx_state_nx = TX_STOP;
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE;
                w_tx_nx       = 1'b1;
            end
        endcase
    end

    // ---------------- receiver ----------------
    rx_state_e            r_rx_state;
    rx_state_e            w_rx_state_nx;
    logic [3:0]           r_rx_ticks;
    logic [3:0]           w_rx_ticks_nx;
    logic [2:0]           r_rx_bits;
    logic [2:0]           w_rx_bits_nx;
    logic [DATA_BITS-1:0] w_rx_shift_nx;
    logic                 w_rx_mid;
    logic                 w_rx_bit_end;
    logic                 w_frame_evt;
    logic                 w_overrun_evt;

    assign w_rx_mid     = w_tick16 && (r_rx_ticks == MID_LAST);
    assign w_rx_bit_end = w_tick16 && (r_rx_ticks == TICK_LAST);

`ifdef UART_PARITY_EN
    logic       w_parity_evt;
    logic [7:0] w_rx_shift8;

    // Widen the received word for the 8-bit parity helper.
    always_comb begin
        w_rx_shift8                = 8'd0;
        w_rx_shift8[DATA_BITS-1:0] = r_rx_shift;
    end
`endif

    // RX state, bit timing and the assembling shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_ticks <= 4'd0;
            r_rx_bits  <= 3'd0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_state_nx;
            r_rx_ticks <= w_rx_ticks_nx;
            r_rx_bits  <= w_rx_bits_nx;
            r_rx_shift <= w_rx_shift_nx;
        end
    end

    // RX next-state logic; after the mid-start check every sample is 16 ticks on.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_ticks_nx = w_tick16 ? (r_rx_ticks + 4'd1) : r_rx_ticks;
        w_rx_bits_nx  = r_rx_bits;
        w_rx_shift_nx = r_rx_shift;
        w_rx_push     = 1'b0;
        w_frame_evt   = 1'b0;
        w_overrun_evt = 1'b0;
`ifdef UART_PARITY_EN
        w_parity_evt  = 1'b0;
`endif
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_ticks_nx = 4'd0;
                w_rx_bits_nx  = 3'd0;
                if (!r_rx_sync) begin
                    w_rx_state_nx = RX_START;
                end else begin
                    w_rx_state_nx = RX_IDLE;
                end
            end
            RX_START: begin
                if (w_rx_mid) begin
                    // Restart the bit timer so later samples land on bit centres.
                    w_rx_ticks_nx = 4'd0;
                    if (!r_rx_sync) begin
                        w_rx_state_nx = RX_DATA;
                    end else begin
                        w_rx_state_nx = RX_IDLE;
                    end
                end else begin
                    w_rx_state_nx = RX_START;
                end
            end
            RX_DATA: begin
                if (w_rx_bit_end) begin
                    w_rx_shift_nx = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bits == LAST_DATA) begin
                        w_rx_bits_nx  = 3'd0;
`ifdef UART_PARITY_EN
                        w_rx_state_nx = RX_PARITY;
`else
                        w_rx_state_nx = RX_STOP;
`endif
                    end else begin
                        w_rx_bits_nx  = r_rx_bits + 3'd1;
                    end
                end else begin
                    w_rx_state_nx = RX_DATA;
                end
            end
            RX_PARITY: begin
`ifdef UART_PARITY_EN
                if (w_rx_bit_end) begin
                    w_parity_evt  = (r_rx_sync != calc_parity(w_rx_shift8, (PARITY_ODD != 0)));
                    w_rx_state_nx = RX_STOP;
                end else begin
                    w_rx_state_nx = RX_PARITY;
                end
`else
                w_rx_state_nx = RX_IDLE;
`endif
            end
            RX_STOP: begin
                if (w_rx_bit_end) begin
                    w_rx_state_nx = RX_IDLE;
                    if (r_rx_sync) begin
                        if (!w_rx_full) begin
                            w_rx_push     = 1'b1;
                        end else begin
                            w_overrun_evt = 1'b1;
                        end
                    end else begin
                        w_frame_evt = 1'b1;
                    end
                end else begin
                    w_rx_state_nx = RX_STOP;
                end
            end
            default: begin
                w_rx_state_nx = RX_IDLE;
            end
        endcase
    end

    // ---------------- sticky error flags ----------------
    logic r_rx_overrun;
    logic r_frame_err;

    // Sticky flags: an event in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_overrun <= w_overrun_evt || (r_rx_overrun && !clear_err);
            r_frame_err  <= w_frame_evt   || (r_frame_err  && !clear_err);
        end
    end

`ifdef UART_PARITY_EN
    logic r_parity_err;

    // Sticky parity flag with the same clear/event priority as the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_parity_evt || (r_parity_err && !clear_err);
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // ---------------- outputs ----------------
    assign tx         = r_tx;
    assign data_read  = w_rx_head;
    assign data_ready = !w_rx_empty;
    assign tx_full    = w_tx_full;
    assign tx_idle    = w_tx_empty && (r_tx_state == TX_IDLE);
    assign rx_overrun = r_rx_overrun;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_param.sv
// -----------------------------------------------------------------------------
// tb_uart_param
// Scoreboard bench for uart_param: stimulus pushes expected received bytes into
// a queue; a monitor pops and compares whenever data_ready is presented.
// Works with or without UART_PARITY_EN defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_param;

    localparam int  FIFO_DEPTH = 16;
    localparam int  BIT_CLKS   = 64;     // baud_div=3 -> 4 clocks/tick, 16 ticks/bit
    localparam logic PAR_ODD   = 1'b0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic        tb_rx = 1'b1;
    logic        loop_sel = 1'b1;
    logic        rx_line;
    logic        tx;
    logic        write = 1'b0;
    logic [7:0]  data_write = 8'd0;
    logic        read = 1'b0;
    logic [7:0]  data_read;
    logic        data_ready;
    logic        tx_full;
    logic        tx_idle;
    logic [4:0]  rx_level;
    logic [4:0]  tx_level;
    logic        clear_err = 1'b0;
    logic        rx_overrun;
    logic        frame_err;
    logic        parity_err;

    int          n_checks = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    bit          mon_en = 1'b0;

    assign rx_line = loop_sel ? tx : tb_rx;

    uart_param #(
        .DATA_BITS(8), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(16), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .clock(clock), .reset(reset), .baud_div(baud_div), .rx(rx_line), .tx(tx),
        .write(write), .data_write(data_write), .read(read), .data_read(data_read),
        .data_ready(data_ready), .tx_full(tx_full), .tx_idle(tx_idle),
        .rx_level(rx_level), .tx_level(tx_level), .clear_err(clear_err),
        .rx_overrun(rx_overrun), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the RX FIFO presents a byte.
    initial begin
        logic [7:0] e_byte;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && data_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rx_unexpected: got %0h with no byte expected", data_read);
                end else begin
                    e_byte = exp_q.pop_front();
                    check("rx_data", {24'd0, data_read}, {24'd0, e_byte});
                end
                read = 1'b1;
                @(negedge clock);
                read = 1'b0;
            end
        end
    end

    task automatic tx_write(input logic [7:0] d);
        @(negedge clock);
        data_write = d;
        write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    // Drive one serial frame on tb_rx (LSB first, optional parity, one stop).
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        @(negedge clock);
        tb_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            tb_rx = d[i];
            repeat (BIT_CLKS) @(negedge clock);
        end
`ifdef UART_PARITY_EN
        tb_rx = (^d) ^ PAR_ODD ^ bad_par;
        repeat (BIT_CLKS) @(negedge clock);
`endif
        if (bad_stop) begin
            tb_rx = 1'b0;
            repeat (40) @(negedge clock);
            tb_rx = 1'b1;
            repeat (100) @(negedge clock);
        end else begin
            tb_rx = 1'b1;
            repeat (80) @(negedge clock);
        end
    endtask

    // Watch tx for one frame and compare each bit at its centre.
    task automatic check_tx_frame(input logic [7:0] d);
        logic [11:0] fb;
        int          nb;
        bit          found;
        fb = 12'd0;
        nb = 0;
        fb[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            fb[nb] = d[i]; nb++;
        end
`ifdef UART_PARITY_EN
        fb[nb] = (^d) ^ PAR_ODD; nb++;
`endif
        fb[nb] = 1'b1; nb++;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock);
            if (tx == 1'b0) found = 1'b1;
        end
        check("tx_start_seen", {31'd0, found}, 32'd1);
        if (found) begin
            for (int k = 1; k < nb * BIT_CLKS; k++) begin
                @(negedge clock);
                if (k == BIT_CLKS - 1) check("tx_start_last_clk", {31'd0, tx}, 32'd0);
                if (k == BIT_CLKS)     check("tx_bit0_first_clk", {31'd0, tx}, {31'd0, fb[1]});
                if (k % BIT_CLKS == 32)
                    check($sformatf("tx_bit%0d", k / BIT_CLKS), {31'd0, tx}, {31'd0, fb[k / BIT_CLKS]});
            end
        end
    endtask

    task automatic wait_tx_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (tx_idle) ok = 1'b1;
        end
        check(name, {31'd0, tx_idle}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 15000 && !ok; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !data_ready) ok = 1'b1;
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         model_cnt;
        bit         ok;

        // Reset values
        repeat (5) @(negedge clock);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_data_ready", {31'd0, data_ready}, 32'd0);
        check("rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
        check("rst_rx_level", {27'd0, rx_level}, 32'd0);
        check("rst_tx_level", {27'd0, tx_level}, 32'd0);
        check("rst_flags", {29'd0, rx_overrun, frame_err, parity_err}, 32'd0);
        reset = 1'b0;

        // 0xA5 on the wire, looped back into the receiver
        mon_en = 1'b1;
        exp_q.push_back(8'hA5);
        tx_write(8'hA5);
        check_tx_frame(8'hA5);
        wait_tx_idle("tx_idle_after_a5");
        wait_drain("drain_a5");

        // Single loopback byte held in the RX FIFO, then read out
        mon_en = 1'b0;
        tx_write(8'h3C);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clock);
            if (data_ready) ok = 1'b1;
        end
        check("rx_ready_3c", {31'd0, data_ready}, 32'd1);
        check("rx_head_3c", {24'd0, data_read}, 32'h3C);
        check("rx_level_one", {27'd0, rx_level}, 32'd1);
        exp_q.push_back(8'h3C);
        mon_en = 1'b1;
        wait_drain("drain_3c");
        check("rx_ready_after_read", {31'd0, data_ready}, 32'd0);
        wait_tx_idle("tx_idle_after_3c");

        // Random burst: one byte leaves the FIFO at once, the rest queue up
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            @(negedge clock);
            data_write = d;
            write = 1'b1;
        end
        @(negedge clock);
        write = 1'b0;
        check("tx_level_burst", {27'd0, tx_level}, 32'd9);
        check("tx_full_burst", {31'd0, tx_full}, 32'd0);
        wait_drain("drain_burst");
        wait_tx_idle("tx_idle_after_burst");

        // Reset in the middle of a frame
        mon_en = 1'b0;
        tx_write(8'($urandom));
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (!tx) ok = 1'b1;
        end
        check("mid_reset_started", {31'd0, ok}, 32'd1);
        repeat (100) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_tx_high", {31'd0, tx}, 32'd1);
        check("mid_reset_tx_idle", {31'd0, tx_idle}, 32'd1);
        reset = 1'b0;
        repeat (800) @(negedge clock);
        check("mid_reset_no_push", {27'd0, rx_level}, 32'd0);
        check("mid_reset_flags", {29'd0, rx_overrun, frame_err, parity_err}, 32'd0);

        // Framing error: stop bit low
        loop_sel = 1'b0;
        mon_en = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("frame_err_set", {31'd0, frame_err}, 32'd1);
        check("frame_err_no_push", {27'd0, rx_level}, 32'd0);
        pulse_clear();
        check("frame_err_cleared", {31'd0, frame_err}, 32'd0);

        // Short low glitch: rejected at the mid-start check
        @(negedge clock);
        tb_rx = 1'b0;
        repeat (20) @(negedge clock);
        tb_rx = 1'b1;
        repeat (200) @(negedge clock);
        check("glitch_no_push", {27'd0, rx_level}, 32'd0);
        check("glitch_no_flags", {29'd0, rx_overrun, frame_err, parity_err}, 32'd0);

`ifdef UART_PARITY_EN
        // Parity generation on TX and checking on RX
        loop_sel = 1'b1;
        exp_q.push_back(8'h07);
        tx_write(8'h07);
        check_tx_frame(8'h07);
        wait_drain("drain_07");
        check("parity_ok_no_err", {31'd0, parity_err}, 32'd0);
        loop_sel = 1'b0;
        exp_q.push_back(8'h6B);
        send_frame(8'h6B, 1'b1, 1'b0);
        wait_drain("drain_bad_parity");
        check("parity_err_set", {31'd0, parity_err}, 32'd1);
        pulse_clear();
        check("parity_err_cleared", {31'd0, parity_err}, 32'd0);
`endif

        // Overrun: one frame more than the RX FIFO holds, no reads meanwhile
        loop_sel = 1'b0;
        mon_en = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            d = 8'($urandom);
            if (model_cnt < FIFO_DEPTH) begin
                exp_q.push_back(d);
                model_cnt++;
            end
            send_frame(d, 1'b0, 1'b0);
        end
        check("overrun_flag", {31'd0, rx_overrun}, 32'd1);
        check("overrun_level", {27'd0, rx_level}, FIFO_DEPTH);
        check("overrun_no_frame_err", {31'd0, frame_err}, 32'd0);
        mon_en = 1'b1;
        wait_drain("drain_overrun");
        pulse_clear();
        check("overrun_cleared", {31'd0, rx_overrun}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter DATA_BITS, default 8: frame data width; legal range 5..8.
REQ-002 Parameter FIFO_DEPTH, default 16: entries per RX and TX FIFO; power of two, 4 or more.
REQ-003 Parameter DIV_W, default 16: width of the baud_div port.
REQ-004 Parameter STOP_BITS, default 1: TX stop bits, 1 or 2; RX checks only the first stop bit.
REQ-005 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only when UART_PARITY_EN is defined.
REQ-006 Port clock, input, 1: system clock; all logic is on its rising edge.
REQ-007 Port reset, input, 1: reset, synchronous, active-high.
REQ-008 Port baud_div, input, DIV_W: clocks per 16x oversample tick, minus 1.
REQ-009 Port rx, input, 1: serial input, asynchronous.
REQ-010 Port tx, output, 1: serial output; idles high.
REQ-011 Port write, input, 1: push data_write into the TX FIFO.
REQ-012 Port data_write, input, DATA_BITS: TX data.
REQ-013 Port read, input, 1: pop the RX FIFO.
REQ-014 Port data_read, output, DATA_BITS: RX FIFO head (first-word fall-through).
REQ-015 Port data_ready, output, 1: RX FIFO not empty.
REQ-016 Port tx_full, output, 1: TX FIFO full.
REQ-017 Port tx_idle, output, 1: TX FIFO empty and TX FSM in IDLE.
REQ-018 Port rx_level and tx_level, output, $clog2(FIFO_DEPTH)+1 each: FIFO occupancy.
REQ-019 Port clear_err, input, 1: clears all sticky error flags.
REQ-020 Port rx_overrun, frame_err, parity_err, output, 1 each: sticky error flags.

Function
REQ-021 The tick counter SHALL count 0..baud_div and pulse tick16 for one clock on wrap; a new baud_div value SHALL take effect at the next wrap.
REQ-022 rx SHALL pass through a 2-flop synchroniser before any use, giving 2 clocks of latency.
REQ-023 The TX FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with each bit lasting 16 tick16 pulses.
REQ-024 In IDLE, on tick16 with the TX FIFO non-empty, TX SHALL pop the head, latch it and enter START in the same cycle.
REQ-025 TX SHALL shift data LSB first, send DATA_BITS bits, then PARITY (macro only), then STOP_BITS x 16 ticks high, then return to IDLE.
REQ-026 The RX FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-027 In IDLE, a synchronised low SHALL enter START; at tick 8 of START, low continues the frame and high returns to IDLE (glitch reject).
REQ-028 RX SHALL sample each later bit after a further 16 ticks, at bit centre.
REQ-029 A low stop sample SHALL set frame_err, discard the byte and return RX to IDLE.
REQ-030 A valid byte SHALL be pushed into the RX FIFO in the cycle the stop bit is sampled.
REQ-031 If the RX FIFO is full when a push is due, RX SHALL drop the byte and set rx_overrun.
REQ-032 A write while full SHALL be ignored; a read while empty SHALL be ignored.
REQ-033 Read and write together: when full, both SHALL occur; when empty, only the write SHALL occur.
REQ-034 Level counters SHALL saturate neither way, since legal operation never wraps them; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-035 clear_err SHALL clear all flags; an error event in the same cycle SHALL win and set the flag.

Reset
REQ-036 On reset: tx=1, both FSMs IDLE, FIFOs empty, levels 0, data_ready=0, tx_full=0, tx_idle=1, all error flags 0, tick counter 0, synchroniser flops 1.
REQ-037 Reset mid-frame SHALL abort the frame; tx SHALL be high on the next clock and no partial byte SHALL be pushed.

Configuration
REQ-038 With UART_PARITY_EN defined, TX SHALL insert a parity bit and RX SHALL check it.
REQ-039 With UART_PARITY_EN defined, a parity mismatch SHALL set parity_err and the byte SHALL still be pushed.
REQ-040 Without UART_PARITY_EN, the PARITY state SHALL be unreachable and parity_err SHALL be tied to 0.

Structure
REQ-041 Package uart_pkg SHALL hold the TX/RX state enums and the constants OVERSAMPLE=16 and SAMPLE_MID=8.
REQ-042 The sub-module uart_fifo (parameters WIDTH, DEPTH; first-word fall-through; level output) SHALL be instantiated twice.

Verification
REQ-043 Scenario: baud_div=3, write 0xA5 -> tx low 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, stop high, then tx_idle=1.
REQ-044 Scenario: tx looped to rx, write 0x3C -> data_ready=1, data_read=0x3C, rx_level=1; read -> data_ready=0.
REQ-045 Scenario: 17 frames with no reads at FIFO_DEPTH=16 -> rx_overrun=1, rx_level=16, the first 16 bytes intact in order.
REQ-046 Scenario: frame with stop bit driven low -> frame_err=1, rx_level unchanged; then clear_err -> 0.
REQ-047 Scenario: rx low for 5 ticks only -> no start, no push, no flags.
REQ-048 Scenario: with UART_PARITY_EN and even parity, 0x07 -> parity bit 1; flipped parity on RX -> parity_err=1 and the byte is pushed.
